// File: rtl/cdc_pkg.sv
// Shared CDC definitions for the handshake transmitter and the receiver.
//   hs_tx_state_t : transmit-side handshake state
//   SYNC_MIN      : minimum synchronizer depth accepted by the CDC blocks
package cdc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      REL  = 2'd2
   } hs_tx_state_t;

   localparam int SYNC_MIN = 2;

endpackage

// File: rtl/sync_ff.sv
// N-stage single-bit synchronizer. All stages reset to 0.
// Ports:
//   clk_i : destination clock
//   rst_i : asynchronous active-high reset
//   d_i   : asynchronous input
//   q_o   : synchronized output (last stage)
module sync_ff #(
   parameter int N = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic [N-1:0] sync_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[N-2:0], d_i};
      end
   end

   assign q_o = sync_q[N-1];

endmodule

// File: rtl/cdc_hs_tx.sv
// Source end of a 4-phase req/ack clock-domain crossing. A word accepted on
// the valid/ready side is held on ODATA while OREQ is raised; the returning
// IACK is synchronized before use. ODATA only changes on accept, so it is
// stable for the whole request/acknowledge cycle.
//
// Optional feature macro: CDC_HS_TX_TIMEOUT_EN
//   defined   : sticky OERR set after TIMEOUT cycles waiting in REQ
//   undefined : no counter, OERR tied to 0
//
// Ports:
//   CLK    : source clock
//   RST    : asynchronous active-high reset
//   IDATA  : word to transfer
//   IVALID : IDATA valid
//   IREADY : word can be accepted this cycle
//   ODATA  : bundled data toward destination (registered)
//   OREQ   : request toward destination (registered)
//   IACK   : acknowledge from destination (asynchronous)
//   OERR   : sticky acknowledge timeout flag (registered)
//
// state | meaning
// IDLE  | waiting for a word
// REQ   | OREQ high, waiting for synchronized ack to rise
// REL   | OREQ low, waiting for synchronized ack to fall
module cdc_hs_tx
   import cdc_pkg::*;
#(
   parameter int W           = 4,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 255
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic [W-1:0] IDATA,
   input  logic         IVALID,
   output logic         IREADY,
   output logic [W-1:0] ODATA,
   output logic         OREQ,
   input  logic         IACK,
   output logic         OERR
);

   if (SYNC_STAGES < SYNC_MIN) begin : g_sync_chk
      $error("cdc_hs_tx: SYNC_STAGES must be at least %0d", SYNC_MIN);
   end
   if (TIMEOUT < 1) begin : g_timeout_chk
      $error("cdc_hs_tx: TIMEOUT must be at least 1");
   end

   hs_tx_state_t state_q;
   logic [W-1:0] odata_q;
   logic         oreq_q;
   logic         ack_s;
   logic         accept;

   sync_ff #(
      .N (SYNC_STAGES)
   ) u_ack_sync (
      .clk_i (CLK),
      .rst_i (RST),
      .d_i   (IACK),
      .q_o   (ack_s)
   );

   // A stale high ack from a previous handshake must drain before a new
   // request can be raised, otherwise REQ would complete immediately.
   assign IREADY = (state_q == IDLE) && !ack_s;
   assign accept = IVALID && IREADY;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         oreq_q  <= 1'b0;
         odata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  odata_q <= IDATA;
                  oreq_q  <= 1'b1;
                  state_q <= REQ;
               end
            end
            REQ: begin
               if (ack_s) begin
                  oreq_q  <= 1'b0;
                  state_q <= REL;
               end
            end
            REL: begin
               if (!ack_s) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               oreq_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign ODATA = odata_q;
   assign OREQ  = oreq_q;

`ifdef CDC_HS_TX_TIMEOUT_EN
   localparam int            CW     = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          oerr_q;

   // Counter saturates so a very long wait cannot wrap and look healthy.
   always_comb begin
      cnt_d = cnt_q;
      if (accept) begin
         cnt_d = '0;
      end else if ((state_q == REQ) && (cnt_q != TO_VAL)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_q  <= '0;
         oerr_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         if (cnt_d == TO_VAL) begin
            oerr_q <= 1'b1;
         end
      end
   end

   assign OERR = oerr_q;
`else
   assign OERR = 1'b0;
`endif

endmodule
